// File: rtl/fine_dco_pkg.sv
// Shared types and constants for the fine DCO control decoder.
// Holds the FSM encoding, field width defaults and the reset mid-code.
package fine_dco_pkg;

  localparam int MSB_W_DEF = 5;
  localparam int LSB_W_DEF = 8;

  localparam logic [4:0] RST_MSB = 5'd16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    TRACK = 2'd2
  } state_t;

endpackage

// File: rtl/fine_dco_ctrl_decoder_dsm.sv
// First-order delta-sigma modulator for the dithered LSB field.
// The carry out of the accumulator drives the single dither unit.
module dsm_first_order #(
  parameter int LSB_W = 8
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [LSB_W-1:0] lsb,
  output logic             dither
);

  logic [LSB_W-1:0] acc;
  logic [LSB_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, lsb};

  // accumulate while enabled, hold otherwise, clear on request
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      dither <= 1'b0;
    end else if (clr) begin
      acc    <= '0;
      dither <= 1'b0;
    end else if (en) begin
      acc    <= sum[LSB_W-1:0];
      dither <= sum[LSB_W];
    end else begin
      dither <= 1'b0;
    end
  end

endmodule

// File: rtl/fine_dco_ctrl_decoder.sv
// Fine DCO control decoder: CDC update capture, MSB ramping and
// thermometer decode, with a dithered unit driven by the LSB field.
module fine_dco_ctrl_decoder
  import fine_dco_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MSB_W       = MSB_W_DEF,
  parameter int LSB_W       = LSB_W_DEF
) (
  input  logic                   clk_out,
  input  logic                   rst,
  input  logic                   dsm_en,
  input  logic                   upd_tgl,
  input  logic [MSB_W+LSB_W-1:0] ctrl_word,
  output logic                   upd_ack,
  output logic [2**MSB_W-1:0]    therm_ctrl,
  output logic [MSB_W-1:0]       cur_msb,
  output logic                   busy
);

  localparam int TW = 2**MSB_W;
  localparam int CW = MSB_W + LSB_W;
  localparam logic [MSB_W-1:0] MID = MSB_W'(RST_MSB);
  localparam logic [TW-2:0] THERM_RST =
    (TW-1)'((1 << int'(RST_MSB)) - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   upd_evt;

  state_t           state, state_n;
  logic [MSB_W-1:0] cur_q, cur_n;
  logic [MSB_W-1:0] tgt_q, tgt_n;
  logic [LSB_W-1:0] lsb_q;
  logic [TW-2:0]    therm_q, therm_n;
  logic             dither;

  // bring the update toggle into the clk_out domain
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], upd_tgl};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign upd_evt = sync_q[SYNC_STAGES-1] ^ edge_q;

  // next state, ramp step and retarget handling
  always_comb begin
    tgt_n   = upd_evt ? ctrl_word[CW-1:LSB_W] : tgt_q;
    state_n = state;
    cur_n   = cur_q;
    unique case (state)
      IDLE, TRACK: begin
        if (upd_evt)
          state_n = (tgt_n != cur_q) ? RAMP : TRACK;
      end
      RAMP: begin
        if (cur_q == tgt_n) begin
          state_n = TRACK;
        end else begin
          cur_n = (tgt_n > cur_q) ? cur_q + 1'b1
                                  : cur_q - 1'b1;
          if (cur_n == tgt_n)
            state_n = TRACK;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // thermometer decode of the code about to be applied
  always_comb begin
    therm_n = '0;
    for (int k = 0; k < TW-1; k++)
      therm_n[k] = (32'(k) < 32'(cur_n));
  end

  // state, code, latched word and output registers
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cur_q   <= MID;
      tgt_q   <= MID;
      lsb_q   <= '0;
      upd_ack <= 1'b0;
      busy    <= 1'b0;
      therm_q <= THERM_RST;
    end else begin
      state   <= state_n;
      cur_q   <= cur_n;
      tgt_q   <= tgt_n;
      busy    <= (state_n == RAMP);
      therm_q <= therm_n;
      if (upd_evt) begin
        lsb_q   <= ctrl_word[LSB_W-1:0];
        upd_ack <= ~upd_ack;
      end
    end
  end

  dsm_first_order #(
    .LSB_W(LSB_W)
  ) u_dsm (
    .clk_out(clk_out),
    .rst    (rst),
    .en     (dsm_en && (state == TRACK)),
    .clr    (!dsm_en),
    .lsb    (lsb_q),
    .dither (dither)
  );

  assign cur_msb    = cur_q;
  assign therm_ctrl = {dither, therm_q};

endmodule

// File: tb/tb_fine_dco_ctrl_decoder.sv
// Randomized bench for fine_dco_ctrl_decoder with a behavioural model.
// Every cycle the outputs are compared against the model's view.
module tb_fine_dco_ctrl_decoder;

  localparam int SYNC = 2;

  logic        clk_out = 1'b0;
  logic        rst = 1'b0;
  logic        dsm_en = 1'b0;
  logic        upd_tgl = 1'b0;
  logic [12:0] ctrl_word = '0;
  logic        upd_ack;
  logic [31:0] therm_ctrl;
  logic [4:0]  cur_msb;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  int m_cur, m_tgt, m_lsb, m_acc, m_dith, m_ack;
  bit m_ramping, m_tracking;
  int pend;

  fine_dco_ctrl_decoder #(
    .SYNC_STAGES(SYNC),
    .MSB_W(5),
    .LSB_W(8)
  ) dut (
    .clk_out   (clk_out),
    .rst       (rst),
    .dsm_en    (dsm_en),
    .upd_tgl   (upd_tgl),
    .ctrl_word (ctrl_word),
    .upd_ack   (upd_ack),
    .therm_ctrl(therm_ctrl),
    .cur_msb   (cur_msb),
    .busy      (busy)
  );

  always #5 clk_out = ~clk_out;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = 16; m_tgt = 16; m_lsb = 0;
    m_acc = 0; m_dith = 0; m_ack = 0;
    m_ramping = 0; m_tracking = 0; pend = 0;
  endtask

  task automatic model_step();
    int s;
    bit evt;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_tracking && dsm_en) begin
      s = m_acc + m_lsb;
      m_dith = s / 256;
      m_acc = s % 256;
    end else begin
      m_dith = 0;
    end
    if (!dsm_en) m_acc = 0;
    evt = 0;
    if (pend > 0) begin
      pend--;
      evt = (pend == 0);
    end
    if (evt) begin
      m_tgt = int'(ctrl_word) / 256;
      m_lsb = int'(ctrl_word) % 256;
      m_ack = m_ack ^ 1;
    end
    if (m_ramping) begin
      if (m_cur != m_tgt) m_cur += (m_tgt > m_cur) ? 1 : -1;
      if (m_cur == m_tgt) begin
        m_ramping = 0;
        m_tracking = 1;
      end
    end else if (evt) begin
      m_ramping  = (m_tgt != m_cur);
      m_tracking = !m_ramping;
    end
  endtask

  task automatic check_all();
    logic [31:0] e;
    e = (32'h1 << m_cur) - 32'h1;
    e[31] = m_dith[0];
    chk("therm", therm_ctrl, e);
    chk("cur_msb", 32'(cur_msb), 32'(m_cur));
    chk("busy", 32'(busy), 32'(m_ramping));
    chk("upd_ack", 32'(upd_ack), 32'(m_ack));
  endtask

  task automatic tick();
    @(posedge clk_out);
    model_step();
    @(negedge clk_out);
    check_all();
  endtask

  task automatic send(input logic [12:0] w);
    ctrl_word = w;
    upd_tgl = ~upd_tgl;
    pend = SYNC + 1;
  endtask

  task automatic settle();
    int n = 0;
    while ((pend != 0 || m_ramping) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("settle_timeout", 32'd1, 32'd0);
  endtask

  task automatic count_ones(input string tag, input int exp);
    int c = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      c += int'(therm_ctrl[31]);
    end
    chk(tag, 32'(c), 32'(exp));
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_therm"}, therm_ctrl, 32'h0000FFFF);
    chk({tag, "_cur"}, 32'(cur_msb), 32'd16);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ack"}, 32'(upd_ack), 32'd0);
  endtask

  initial begin
    int n;
    model_reset();
    #1 rst = 1'b1;
    #2 reset_check("rst_async");
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    reset_check("rst_release");

    dsm_en = 1'b1;
    send(13'h1480);
    repeat (SYNC) tick();
    chk("ack_early", 32'(upd_ack), 32'd0);
    tick();
    chk("ack_lat", 32'(upd_ack), 32'd1);
    settle();
    chk("ramp_end", 32'(cur_msb), 32'd20);
    count_ones("dith_128", 128);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(3) == 0) dsm_en = ~dsm_en;
      send(13'($urandom));
      n = 4 + int'($urandom_range(40));
      for (int j = 0; j < n; j++) begin
        tick();
        if ($urandom_range(15) == 0) dsm_en = ~dsm_en;
      end
      settle();
    end

    dsm_en = 1'b1;
    send(13'h1000);
    settle();
    send(13'h1F00);
    n = 0;
    while (m_cur != 25 && n < 60) begin
      tick();
      n++;
    end
    chk("reach_25", 32'(m_cur), 32'd25);
    send(13'h0000);
    settle();
    chk("floor", therm_ctrl & 32'h7FFFFFFF, 32'h0);
    chk("floor_cur", 32'(cur_msb), 32'd0);
    send(13'h1F00);
    settle();
    chk("ceil", therm_ctrl & 32'h7FFFFFFF, 32'h7FFFFFFF);
    send(13'h1F55);
    settle();
    count_ones("dith_55", 8'h55);

    send(13'h1040);
    settle();
    repeat (20) tick();
    dsm_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("dith_off", 32'(therm_ctrl[31]), 32'd0);
    end
    dsm_en = 1'b1;
    count_ones("dith_64", 64);

    send(13'h1000);
    settle();
    count_ones("dith_0", 0);
    send(13'h10FF);
    settle();
    count_ones("dith_255", 255);

    send(13'h0000);
    n = 0;
    while (m_cur != 9 && n < 60) begin
      tick();
      n++;
    end
    chk("reach_9", 32'(cur_msb), 32'd9);
    rst = 1'b1;
    upd_tgl = 1'b0;
    #1 reset_check("rst_mid");
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    reset_check("rst_after");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
